// File: rtl/imem_fetch_port.sv
// imem_fetch_port: boot-loadable instruction memory with a valid/ready fetch
// port. Words are written through the load port while in BOOT; after ld_done
// the core fetches one word per cycle with one-cycle latency, backpressure,
// flush, and misaligned / out-of-range fault reporting.
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word and flag parity mismatches on rsp_perr.
module imem_fetch_port #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_done,
    output logic                     boot,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic                     flush,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [1:0]               rsp_fault,
    output logic                     rsp_perr
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e state_q;

    // Storage array; deliberately not reset so a program survives a core reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
    logic                  par_q [DEPTH];
`endif

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic [1:0]            rsp_fault_q, rsp_fault_d;
`ifdef IMEM_PARITY_EN
    logic                  rsp_perr_q,  rsp_perr_d;
`endif

    logic                  ld_we;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IW-1:0]         rd_idx;
    logic                  misaligned;
    logic                  out_of_range;

    assign word_idx     = {2'b00, req_addr[ADDR_WIDTH-1:2]};
    assign rd_idx       = word_idx[IW-1:0];
    assign misaligned   = (req_addr[1:0] != 2'b00);
    assign out_of_range = (word_idx >= DEPTH_A);

    assign ld_we     = (state_q == BOOT) && ld_en && (32'(ld_addr) < DEPTH);
    assign req_ready = (state_q == RUN) && !flush && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    assign boot      = (state_q == BOOT);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;
`ifdef IMEM_PARITY_EN
    assign rsp_perr  = rsp_perr_q;
`else
    assign rsp_perr  = 1'b0;
`endif

    // BOOT/RUN control: leave BOOT on ld_done, only reset returns to BOOT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else if (state_q == BOOT && ld_done) begin
            state_q <= RUN;
        end
    end

    // Load-port write; ld_en in the ld_done cycle still lands since state is still BOOT.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ld_addr] <= ld_data;
`ifdef IMEM_PARITY_EN
            par_q[ld_addr] <= ^ld_data;
`endif
        end
    end

    // Response register next state: flush wins, then a new fetch, then consumption.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
`ifdef IMEM_PARITY_EN
        rsp_perr_d  = rsp_perr_q;
`endif
        if (flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept) begin
            rsp_valid_d = 1'b1;
            if (misaligned) begin
                rsp_fault_d = FAULT_ALIGN;
                rsp_data_d  = NOP_WORD;
`ifdef IMEM_PARITY_EN
                rsp_perr_d  = 1'b0;
`endif
            end else if (out_of_range) begin
                rsp_fault_d = FAULT_RANGE;
                rsp_data_d  = NOP_WORD;
`ifdef IMEM_PARITY_EN
                rsp_perr_d  = 1'b0;
`endif
            end else begin
                rsp_fault_d = FAULT_OK;
                rsp_data_d  = mem_q[rd_idx];
`ifdef IMEM_PARITY_EN
                rsp_perr_d  = (^mem_q[rd_idx]) != par_q[rd_idx];
`endif
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register; this is the registered read port of the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= FAULT_OK;
`ifdef IMEM_PARITY_EN
            rsp_perr_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
`ifdef IMEM_PARITY_EN
            rsp_perr_q  <= rsp_perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed testbench for imem_fetch_port (default parameters, DEPTH=256).
// Inputs change 1 ns after the rising edge; outputs are checked on the
// falling edge. With IMEM_PARITY_EN defined, a stored bit is flipped to
// exercise the parity error path.
module tb_imem_fetch_port;

    localparam int DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        boot;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic        rsp_perr;

    int checks = 0;
    int errors = 0;

    imem_fetch_port #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH     (DEPTH),
        .NOP_WORD  (32'h0000_0013)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_done  (ld_done),
        .boot     (boot),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_fault(rsp_fault),
        .rsp_perr (rsp_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        ld_done   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;

        // Reset values
        at_neg();
        check("rst_boot",      32'(boot),      32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'h0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_rsp_perr",  32'(rsp_perr),  32'd0);
        step();
        rst_n = 1'b1;

        // Boot: load idx0 with a request pending; it must not be accepted
        ld_en     = 1'b1;
        ld_addr   = 8'd0;
        ld_data   = 32'h0050_0093;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        at_neg();
        check("boot_req_ready", 32'(req_ready), 32'd0);
        step();
        // idx1 written in the same cycle as ld_done
        ld_addr = 8'd1;
        ld_data = 32'h0010_8113;
        ld_done = 1'b1;
        at_neg();
        check("boot_no_rsp", 32'(rsp_valid), 32'd0);
        check("boot_high",   32'(boot),      32'd1);
        step();

        // RUN: first request accepted the cycle boot falls
        ld_en    = 1'b0;
        ld_done  = 1'b0;
        req_addr = 32'h0;
        at_neg();
        check("run_boot_low", 32'(boot),      32'd0);
        check("run_ready",    32'(req_ready), 32'd1);
        check("run_no_rsp",   32'(rsp_valid), 32'd0);
        step();
        req_addr = 32'h4;
        at_neg();
        check("f0_valid", 32'(rsp_valid), 32'd1);
        check("f0_data",  rsp_data,       32'h0050_0093);
        check("f0_fault", 32'(rsp_fault), 32'd0);
        check("f0_perr",  32'(rsp_perr),  32'd0);
        step();
        req_valid = 1'b0;
        at_neg();
        check("f1_valid", 32'(rsp_valid), 32'd1);
        check("f1_data",  rsp_data,       32'h0010_8113);
        check("f1_fault", 32'(rsp_fault), 32'd0);
        step();
        at_neg();
        check("drain_valid", 32'(rsp_valid), 32'd0);

        // Load port ignored in RUN
        ld_en   = 1'b1;
        ld_addr = 8'd0;
        ld_data = 32'hFFFF_FFFF;
        step();
        ld_en = 1'b0;

        // Faults
        req_valid = 1'b1;
        req_addr  = 32'h2;
        step();
        req_addr = 32'(4 * DEPTH);
        at_neg();
        check("mis_fault", 32'(rsp_fault), 32'd1);
        check("mis_data",  rsp_data,       32'h0000_0013);
        step();
        req_addr = 32'(4 * DEPTH + 1);
        at_neg();
        check("oor_fault", 32'(rsp_fault), 32'd2);
        check("oor_data",  rsp_data,       32'h0000_0013);
        check("oor_valid", 32'(rsp_valid), 32'd1);
        step();
        req_valid = 1'b0;
        at_neg();
        check("prio_fault", 32'(rsp_fault), 32'd1);
        check("prio_data",  rsp_data,       32'h0000_0013);
        step();

        // Backpressure: fetch 0 then stall three cycles with another request waiting
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data",  rsp_data,       32'h0050_0093);
            check("stall_fault", 32'(rsp_fault), 32'd0);
            check("stall_ready", 32'(req_ready), 32'd0);
            step();
        end

        // Flush discards the held response; no accept in the flush cycle
        flush = 1'b1;
        rsp_ready = 1'b1;
        at_neg();
        check("flush_ready", 32'(req_ready), 32'd0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        at_neg();
        check("flush_valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1;
        req_addr  = 32'h4;
        step();
        req_valid = 1'b0;
        at_neg();
        check("post_flush_valid", 32'(rsp_valid), 32'd1);
        check("post_flush_data",  rsp_data,       32'h0010_8113);

        // Asynchronous reset while a response is held
        rsp_ready = 1'b0;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_boot",  32'(boot),      32'd1);
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_data",  rsp_data,       32'h0);
        check("arst_fault", 32'(rsp_fault), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd0);
        check("arst_perr",  32'(rsp_perr),  32'd0);
        at_neg();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        step();
        ld_done = 1'b1;
        step();
        ld_done   = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_valid = 1'b0;
        at_neg();
        check("rerun_valid", 32'(rsp_valid), 32'd1);
        check("rerun_data",  rsp_data,       32'h0050_0093);
        step();

        // Parity error path
`ifdef IMEM_PARITY_EN
        dut.mem_q[0][0] = ~dut.mem_q[0][0];
`endif
        req_valid = 1'b1;
        req_addr  = 32'h0;
        step();
        req_valid = 1'b0;
        at_neg();
`ifdef IMEM_PARITY_EN
        check("par_perr", 32'(rsp_perr), 32'd1);
        check("par_data", rsp_data,      32'h0050_0092);
`else
        check("par_perr_off", 32'(rsp_perr), 32'd0);
        check("par_data_off", rsp_data,      32'h0050_0093);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
